// File: rtl/sipo_frame_controller.sv
// Serial-in/parallel-out frame controller: start opens a frame, WIDTH
// qualified bits are shifted in, and the word is held under valid/ready.
// Ports: clk, rst (sync, active-high), start, sin, sin_valid, pready in;
//   pdata, pvalid, busy, bit_cnt, overrun (sticky), perr out.
// Build option: define SIPO_PARITY_EN to add an even-parity bit per frame.
module sipo_frame_controller #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sin,
  input  logic                       sin_valid,
  input  logic                       pready,
  output logic [WIDTH-1:0]           pdata,
  output logic                       pvalid,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun,
  output logic                       perr
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef SIPO_PARITY_EN
    PARITY = 2'd3,
`endif
    HOLD   = 2'd2
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_sh;

  always_comb begin
    if (MSB_FIRST) sr_sh = {sr[WIDTH-2:0], sin};
    else           sr_sh = {sin, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = SHIFT;
      SHIFT: begin
        if (!start && sin_valid && bit_cnt == LAST) begin
`ifdef SIPO_PARITY_EN
          nxt = PARITY;
`else
          nxt = HOLD;
`endif
        end
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (start)          nxt = SHIFT;
        else if (sin_valid) nxt = HOLD;
      end
`endif
      HOLD: if (pready) nxt = start ? SHIFT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: a start in IDLE, SHIFT, PARITY or an accepting HOLD
  // cycle always opens a clean frame; sin on that cycle is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      pdata   <= '0;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sr      <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (start) begin
            sr      <= '0;
            bit_cnt <= '0;
          end else if (sin_valid) begin
            sr      <= sr_sh;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == LAST) pdata <= sr_sh;
          end
        end
`ifdef SIPO_PARITY_EN
        PARITY: begin
          if (start) begin
            sr      <= '0;
            bit_cnt <= '0;
          end
        end
`endif
        HOLD: begin
          if (sin_valid) overrun <= 1'b1;
          if (pready && start) begin
            sr      <= '0;
            bit_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SIPO_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else if (state == PARITY && !start && sin_valid) begin
      perr_q <= ^{pdata, sin};
    end
  end

  assign perr = perr_q;
  assign busy = (state == SHIFT) || (state == PARITY);
`else
  assign perr = 1'b0;
  assign busy = (state == SHIFT);
`endif

  assign pvalid = (state == HOLD);

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Directed bench for sipo_frame_controller: MSB-first and LSB-first
// instances share stimulus; a scoreboard holds expected words.
module tb_sipo_frame_controller;

  logic clk = 1'b0;
  logic rst, start, sin, sin_valid, pready;

  logic [2:0] pd_m, pd_l;
  logic [1:0] bc_m, bc_l;
  logic pv_m, pv_l, bz_m, bz_l, ov_m, ov_l, pe_m, pe_l;

  always #5 clk = ~clk;

  sipo_frame_controller #(.WIDTH(3), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .start(start), .sin(sin),
    .sin_valid(sin_valid), .pready(pready), .pdata(pd_m),
    .pvalid(pv_m), .busy(bz_m), .bit_cnt(bc_m),
    .overrun(ov_m), .perr(pe_m)
  );

  sipo_frame_controller #(.WIDTH(3), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .start(start), .sin(sin),
    .sin_valid(sin_valid), .pready(pready), .pdata(pd_l),
    .pvalid(pv_l), .busy(bz_l), .bit_cnt(bc_l),
    .overrun(ov_l), .perr(pe_l)
  );

  typedef struct {
    logic [2:0] m;
    logic [2:0] l;
    logic       pe;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic sv,
                      input logic s, input logic pr);
    start     = st;
    sin_valid = sv;
    sin       = s;
    pready    = pr;
    @(posedge clk);
    #1;
  endtask

  // seq[2] is the first serial bit on the wire.
  task automatic push_frame(input logic [2:0] seq, input logic par,
                            input logic sv0);
    exp_t e;
    step(1'b1, sv0, 1'b1, 1'b0);
    chk("open_busy", {31'd0, bz_m}, 1);
    chk("open_cnt", {30'd0, bc_m}, 0);
    step(1'b0, 1'b1, seq[2], 1'b0);
    step(1'b0, 1'b1, seq[1], 1'b0);
    chk("mid_cnt", {30'd0, bc_m}, 2);
    chk("mid_pv", {31'd0, pv_m}, 0);
    step(1'b0, 1'b1, seq[0], 1'b0);
`ifdef SIPO_PARITY_EN
    chk("par_pv", {31'd0, pv_m}, 0);
    chk("par_busy", {31'd0, bz_m}, 1);
    step(1'b0, 1'b1, par, 1'b0);
    e.pe = ^{seq, par};
`else
    e.pe = 1'b0;
`endif
    e.m = seq;
    e.l = {seq[0], seq[1], seq[2]};
    q.push_back(e);
  endtask

  task automatic check_word(input string tag);
    exp_t e;
    chk({tag, "_pv_m"}, {31'd0, pv_m}, 1);
    chk({tag, "_pv_l"}, {31'd0, pv_l}, 1);
    chk({tag, "_busy"}, {31'd0, bz_m}, 0);
    chk({tag, "_cnt"}, {30'd0, bc_m}, 3);
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = q.pop_front();
      chk({tag, "_pd_m"}, {29'd0, pd_m}, {29'd0, e.m});
      chk({tag, "_pd_l"}, {29'd0, pd_l}, {29'd0, e.l});
      chk({tag, "_perr"}, {31'd0, pe_m}, {31'd0, e.pe});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pd_m"}, {29'd0, pd_m}, 0);
    chk({tag, "_pd_l"}, {29'd0, pd_l}, 0);
    chk({tag, "_pv"}, {31'd0, pv_m}, 0);
    chk({tag, "_busy"}, {31'd0, bz_m}, 0);
    chk({tag, "_cnt"}, {30'd0, bc_m}, 0);
    chk({tag, "_ovr"}, {31'd0, ov_m}, 0);
    chk({tag, "_perr"}, {31'd0, pe_m}, 0);
  endtask

  initial begin
    logic [2:0] held;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check_zero("reset");

    // IDLE ignores sin_valid for overrun
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("idle_ovr", {31'd0, ov_m}, 0);
    chk("idle_busy", {31'd0, bz_m}, 0);

    // Frame 1,1,0 then hold with pready low
    push_frame(3'b110, 1'b0, 1'b0);
    check_word("f110");
    held = pd_m;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold_pv", {31'd0, pv_l}, 1);
      chk("hold_pd", {29'd0, pd_m}, {29'd0, held});
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("acc_pv", {31'd0, pv_m}, 0);
    chk("acc_busy", {31'd0, bz_m}, 0);

    // Abort: one bit, restart with a live bit, then 0,0,1
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("abort_cnt1", {30'd0, bc_m}, 1);
    push_frame(3'b001, 1'b1, 1'b1);
    check_word("f001");
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Start with sin_valid in IDLE drops that bit
    push_frame(3'b011, 1'b1, 1'b1);
    check_word("f011");
    held = pd_m;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovr_set", {31'd0, ov_m}, 1);
    chk("ovr_pd", {29'd0, pd_m}, {29'd0, held});
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("st_nordy_pv", {31'd0, pv_m}, 1);
    chk("ovr_sticky", {31'd0, ov_l}, 1);

    // Back-to-back: accept and restart in one cycle
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("b2b_busy", {31'd0, bz_m}, 1);
    chk("b2b_cnt", {30'd0, bc_m}, 0);
    chk("b2b_pv", {31'd0, pv_m}, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    step(1'b0, 1'b1, 1'b1, 1'b0);
    q.push_back('{m: 3'b100, l: 3'b001, pe: 1'b0});
`else
    q.push_back('{m: 3'b100, l: 3'b001, pe: 1'b0});
`endif
    check_word("f100");
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_keep", {31'd0, ov_m}, 1);

    // Reset mid-frame after two bits
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check_zero("midrst");
    push_frame(3'b101, 1'b0, 1'b0);
    check_word("f101");
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Parity-bit value 1 on 1,1,0 (perr=1 with parity build)
    push_frame(3'b110, 1'b1, 1'b0);
    check_word("f110p1");
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("end_pv", {31'd0, pv_m}, 0);
    chk("sb_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sipo_frame_controller.md
# sipo_frame_controller

Sequences a serial-in/parallel-out shift register into framed parallel words. A frame is opened by `start` and collects exactly WIDTH qualified serial bits. The word is then held with a valid/ready handshake until the consumer takes it. The block sits between a serial bit source and the parallel consumer, and owns the shift register, bit counter and frame state.

## Interface
- WIDTH, 3, data bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in pdata[WIDTH-1]; 0: first received bit lands in pdata[0].
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  opens a frame; restarts a frame in progress.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this cycle.
- pready  input  1  consumer accepts pdata.
- pdata  output  WIDTH  parallel word; registered.
- pvalid  output  1  pdata holds a complete frame.
- busy  output  1  state is SHIFT or PARITY.
- bit_cnt  output  $clog2(WIDTH+1)  data bits captured in the current frame.
- overrun  output  1  sticky: a bit arrived while a word was pending.
- perr  output  1  parity error for the held word; valid only while pvalid=1.

## Operation
- States: IDLE, SHIFT, PARITY (only with SIPO_PARITY_EN), HOLD. Reset state is IDLE.
- IDLE:
  - busy=0, pvalid=0.
  - sin_valid is ignored and does not set overrun.
  - start=1: go to SHIFT, bit_cnt=0, shift register cleared.
- SHIFT, per sin_valid=1 cycle:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
  - bit_cnt increments.
  - On the WIDTH-th bit: go to HOLD (or PARITY with the macro) and load pdata from the final shifted value.
- SHIFT with sin_valid=0: hold state, sr and bit_cnt unchanged.
- start=1 in SHIFT or PARITY: abort. Partial bits are discarded, bit_cnt=0, state stays or returns to SHIFT, and sin on that cycle is not captured.
- start together with sin_valid in IDLE: the frame opens and that bit is dropped. The first data bit is the next qualified cycle.
- HOLD:
  - pvalid=1, pdata stable.
  - pready=1 completes the transfer. With start=1 in the same cycle, go directly to SHIFT (back-to-back frames, no IDLE cycle). Otherwise go to IDLE.
  - start without pready is ignored.
  - sin_valid=1 sets overrun and the bit is dropped.
- overrun clears only on rst.
- Reset mid-operation: the next cycle shows state IDLE and all outputs 0 (pdata, pvalid, busy, bit_cnt, overrun, perr).

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Latency: start at cycle 0, bits at cycles 1..WIDTH, pvalid=1 from cycle WIDTH+1 (WIDTH+2 with parity).
- pvalid deasserts on the cycle after pready=1 is sampled in HOLD.
- Throughput with pready tied high and start pulsed in the accept cycle: one word per WIDTH+1 cycles (WIDTH+2 with parity).
- bit_cnt reads WIDTH in HOLD and PARITY. It resets to 0 on start.

## Configuration
- SIPO_PARITY_EN defined:
  - After the WIDTH-th data bit, the state is PARITY. The next sin_valid bit is the even-parity bit.
  - Then go to HOLD with perr = ^{pdata, parity_bit}.
  - bit_cnt does not count the parity bit.
- SIPO_PARITY_EN undefined:
  - There is no PARITY state and SHIFT goes directly to HOLD.
  - perr is tied 0.
  - The port list is identical in both builds.

## Test plan
- WIDTH=3, MSB_FIRST=1, start, then bits 1,1,0 on consecutive cycles -> pdata=3'b110, pvalid=1 at cycle 4, busy=0, bit_cnt=3.
- MSB_FIRST=0, same bits 1,1,0 -> pdata=3'b011. Holding pready=0 for 5 cycles keeps pvalid=1 and pdata unchanged.
- Bit 1, then start again, then bits 0,0,1 -> pdata=3'b001. The aborted bit is absent.
- In HOLD with pready=0, pulse sin_valid with sin=1 -> overrun=1 stays set and pdata unchanged. Then pready=1 with start=1 -> next cycle busy=1, bit_cnt=0, pvalid=0.
- rst=1 after 2 of 3 bits -> next cycle state IDLE, all outputs 0. A new frame 1,0,1 -> pdata=3'b101.
- SIPO_PARITY_EN, bits 1,1,0 then parity 0 -> perr=0. Parity 1 -> perr=1. Both appear at cycle 5 with pvalid=1.
